// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
//
// PS/2 keyboard receiver. Synchronises and de-glitches the raw PS/2 pins,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) with an
// inter-bit watchdog, folds E0/F0 prefixes into make/break events carrying
// an extended flag, and queues the events in a first-word-fall-through FIFO.
//
// Ports:
//   clk_100mhz   system clock
//   rst          synchronous active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   ev_valid     FIFO non-empty; head event on ev_code/ev_release/ev_extended
//   ev_ready     consumer accepts the head event
//   ev_code      scan code of the head event, prefixes stripped
//   ev_release   1 = break (key released), 0 = make
//   ev_extended  1 = code was E0-prefixed
//   ev_count     FIFO occupancy
//   overflow     sticky: an event was dropped because the FIFO was full
//   frame_err    one-cycle pulse on parity, stop or watchdog error
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk_100mhz,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_release,
  output logic                          ev_extended,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // -------------------------------------------------------------------------
  // Input path: 2-flop synchroniser, then a shift-register glitch filter.
  // The filtered level only moves when every sample in the window agrees.
  // -------------------------------------------------------------------------
  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_sr, data_sr;
  logic                  clk_filt, data_filt, clk_filt_d;
  logic                  fall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_sr     <= '1;
      data_sr    <= '1;
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_sr     <= {clk_sr[FILTER_LEN-2:0], clk_sync[1]};
      data_sr    <= {data_sr[FILTER_LEN-2:0], data_sync[1]};
      if (&clk_sr)       clk_filt  <= 1'b1;
      else if (~|clk_sr) clk_filt  <= 1'b0;
      if (&data_sr)       data_filt <= 1'b1;
      else if (~|data_sr) data_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  // Clock and data share identical pipelines, so data_filt is aligned with
  // the fall pulse.
  assign fall = clk_filt_d & ~clk_filt;

  // -------------------------------------------------------------------------
  // Frame FSM and watchdog
  // -------------------------------------------------------------------------
  state_t          state_q, state_nx;
  logic [2:0]      bit_cnt_q, bit_cnt_nx;
  logic [7:0]      shift_q, shift_nx;
  logic            par_q, par_nx;
  logic            byte_ok, byte_ok_nx;
  logic            frame_err_nx;
  logic [WD_W-1:0] wd_q;
  logic            timeout;

  assign timeout = (state_q != IDLE) && (wd_q == WD_MAX);

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_nx;
      bit_cnt_q <= bit_cnt_nx;
      shift_q   <= shift_nx;
      par_q     <= par_nx;
      byte_ok   <= byte_ok_nx;
      frame_err <= frame_err_nx;
      if (state_q == IDLE || fall || timeout) wd_q <= '0;
      else                                    wd_q <= wd_q + 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx     = state_q;
    bit_cnt_nx   = bit_cnt_q;
    shift_nx     = shift_q;
    par_nx       = par_q;
    byte_ok_nx   = 1'b0;
    frame_err_nx = 1'b0;
    if (timeout) begin
      // Stalled frame: abandon the partial byte.
      state_nx     = IDLE;
      frame_err_nx = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_filt) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end
        end
        DATA: begin
          shift_nx   = {data_filt, shift_q[7:1]};
          bit_cnt_nx = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = data_filt;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (data_filt && (^{shift_q, par_q})) byte_ok_nx   = 1'b1;
          else                                  frame_err_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Prefix decoder. shift_q holds the finished byte while byte_ok is high.
  // -------------------------------------------------------------------------
  logic       ext_pend, brk_pend;
  logic       is_prefix;
  logic       push;
  logic [9:0] push_data;

  assign is_prefix = shift_q inside {8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF};
  assign push      = byte_ok && !is_prefix;
  assign push_data = {shift_q, brk_pend, ext_pend};

  always_ff @(posedge clk_100mhz) begin
    if (rst || frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_ok) begin
      case (shift_q)
        8'hE0:   ext_pend <= 1'b1;
        8'hF0:   brk_pend <= 1'b1;
        8'hE1:   ;  // pause-sequence prefix: ignored, flags kept
        default: begin  // real code, or 00/FF keyboard error: flags consumed
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO, first-word fall-through
  // -------------------------------------------------------------------------
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, push_ok;
  logic [9:0]       head;

  assign full    = (count == CNT_MAX);
  assign ev_valid = (count != '0);
  assign pop     = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // pointers, so stale contents are never presented.
  always_ff @(posedge clk_100mhz) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Fields are forced to zero while empty so the outputs read 0 after reset.
  assign head        = ev_valid ? mem[rd_ptr] : '0;
  assign ev_code     = head[9:2];
  assign ev_release  = head[1];
  assign ev_extended = head[0];
  assign ev_count    = count;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx
//
// Drives PS/2 frames onto the raw pins and scoreboards decoded key events.
// Expected events are queued as frames are sent; a negedge monitor pops and
// compares them whenever the DUT hands an event over.
// The PS/2 clock runs much faster than a real keyboard and the watchdog is
// shortened, so the whole run stays short; the structure of frames is real.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int FIFO_DEPTH     = 8;
  localparam int HALF           = 40;  // PS/2 half period in system cycles
  // Raw pin edge -> ev_valid: 2 sync flops, FILTER_LEN shifts, filtered
  // register (fall cycle T), byte_ok at T+1, FIFO visible at T+2.
  localparam int LAT            = FILTER_LEN + 5;

  logic       clk_100mhz = 1'b0;
  logic       rst        = 1'b1;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       ev_ready   = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_release;
  logic       ev_extended;
  logic [$clog2(FIFO_DEPTH):0] ev_count;
  logic       overflow;
  logic       frame_err;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_release (ev_release),
    .ev_extended(ev_extended),
    .ev_count   (ev_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  got_e, exp_e;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   valid_rise_cyc = -1;
  logic prev_valid = 1'b0;
  int   last_fall_cyc = 0;
  int   stop_fall_cyc = 0;
  event stop_fall_ev;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_100mhz) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (frame_err) err_seen++;
      if (ev_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = ev_valid;
      if (ev_valid && ev_ready) begin
        got_e = '{code: ev_code, rel: ev_release, ext: ev_extended};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got code=%02h rel=%0b ext=%0b, required no event",
                   got_e.code, got_e.rel, got_e.ext);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            errors++;
            $display("FAIL event_fields: got code=%02h rel=%0b ext=%0b, required code=%02h rel=%0b ext=%0b",
                     got_e.code, got_e.rel, got_e.ext, exp_e.code, exp_e.rel, exp_e.ext);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input logic is_stop);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (is_stop) begin
      stop_fall_cyc = cyc;
      -> stop_fall_ev;
    end
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(stop, 1'b1);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic push_exp(input logic [7:0] code, input logic rel, input logic ext);
    exp_q.push_back('{code: code, rel: rel, ext: ext});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_cyc(1);
    wait_cyc(5);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(3);
    checks += 5;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b, required 0", ev_valid); end
    if (ev_count !== '0)   begin errors++; $display("FAIL reset_ev_count: got %0d, required 0", ev_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    if (ev_code !== 8'h00) begin errors++; $display("FAIL reset_ev_code: got %02h, required 00", ev_code); end
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_make();
    int e0;
    e0 = err_seen;
    ev_ready = 1'b1;
    valid_rise_cyc = -1;
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    // Short clock glitch with data held low: a leaked fall would open a frame
    // that later times out.
    ps2_data = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYCLES + 50);
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL make_events_left: got %0d pending, required 0", exp_q.size()); end
    if (valid_rise_cyc - stop_fall_cyc != LAT) begin
      errors++; $display("FAIL make_latency: got %0d cycles, required %0d", valid_rise_cyc - stop_fall_cyc, LAT);
    end
    if (err_seen != e0) begin errors++; $display("FAIL make_frame_err: got %0d pulses, required 0", err_seen - e0); end
  endtask

  task automatic test_break();
    int e0;
    e0 = err_seen;
    ev_ready = 1'b1;
    push_exp(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain();
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL break_events_left: got %0d pending, required 0", exp_q.size()); end
    if (err_seen != e0) begin errors++; $display("FAIL break_frame_err: got %0d pulses, required 0", err_seen - e0); end
  endtask

  task automatic test_extended();
    int e0;
    e0 = err_seen;
    ev_ready = 1'b1;
    push_exp(8'h74, 1'b0, 1'b1);
    push_exp(8'h74, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    wait_drain();
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ext_events_left: got %0d pending, required 0", exp_q.size()); end
    if (err_seen != e0) begin errors++; $display("FAIL ext_frame_err: got %0d pulses, required 0", err_seen - e0); end
  endtask

  task automatic test_frame_errors();
    int e0;
    e0 = err_seen;
    ev_ready = 1'b1;
    send_frame(8'h1C, 1'b1, 1'b1);  // bad parity
    wait_cyc(20);
    checks++;
    if (err_seen != e0 + 1) begin errors++; $display("FAIL parity_err: got %0d pulses, required 1", err_seen - e0); end
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);  // bad stop bit
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain();
    checks += 2;
    if (err_seen != e0 + 2) begin errors++; $display("FAIL stop_err: got %0d pulses, required 2", err_seen - e0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL err_events_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int e0, lat;
    bit found;
    e0 = err_seen;
    found = 1'b0;
    lat = 0;
    ev_ready = 1'b1;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    for (int i = 0; i < TIMEOUT_CYCLES + 200 && !found; i++) begin
      @(negedge clk_100mhz);
      if (frame_err) begin
        found = 1'b1;
        lat = cyc - last_fall_cyc;
      end
    end
    wait_cyc(5);
    checks += 3;
    if (!found) begin errors++; $display("FAIL timeout_seen: got no frame_err, required one pulse"); end
    if (lat < TIMEOUT_CYCLES + FILTER_LEN + 2 || lat > TIMEOUT_CYCLES + FILTER_LEN + 5) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d",
                         lat, TIMEOUT_CYCLES + FILTER_LEN + 2, TIMEOUT_CYCLES + FILTER_LEN + 5);
    end
    if (err_seen != e0 + 1) begin errors++; $display("FAIL timeout_pulses: got %0d, required 1", err_seen - e0); end
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_recover: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    ev_ready = 1'b1;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    e0 = err_seen;
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain();
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_events_left: got %0d pending, required 0", exp_q.size()); end
    if (err_seen != e0) begin errors++; $display("FAIL midrst_frame_err: got %0d pulses, required 0", err_seen - e0); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < FIFO_DEPTH) push_exp(codes[i], 1'b0, 1'b0);
      send_frame(codes[i], 1'b0, 1'b1);
    end
    wait_cyc(20);
    checks += 2;
    if (ev_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d, required 8", ev_count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, required 1", overflow); end
    // Push while full with a single pop on the very write cycle.
    push_exp(8'h1B, 1'b0, 1'b0);
    fork
      send_frame(8'h1B, 1'b0, 1'b1);
      begin
        @(stop_fall_ev);
        wait_cyc(LAT - 1);
        ev_ready = 1'b1;
        wait_cyc(1);
        ev_ready = 1'b0;
      end
    join
    checks++;
    if (ev_count !== 4'd8) begin errors++; $display("FAIL push_pop_full_count: got %0d, required 8", ev_count); end
    ev_ready = 1'b1;
    wait_drain();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain_events_left: got %0d pending, required 0", exp_q.size()); end
    if (ev_count !== '0) begin errors++; $display("FAIL drain_count: got %0d, required 0", ev_count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b, required 1", overflow); end
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared: got %b, required 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_frame_errors();
    test_timeout();
    test_reset_mid_frame();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete within 100000 cycles");
    $fatal(1);
  end

endmodule
